// File: rtl/rock_sequencer.sv
// rock_sequencer: rate-limited sequencer that walks the live amplitude and
// frequency levels toward a latched target, one level per step. Amplitude is
// lowered before frequency moves and only raised once frequency has settled.
// A calm timeout forces the target to rest (0/0), and an error forces a fast
// one-level-per-tick shutdown with a latched fault.
//
// Optional build macro SOFT_START_EN: when defined, amplitude-raising steps
// take 2*STEP_TICKS ticks instead of STEP_TICKS.
module rock_sequencer #(
    parameter int STEP_TICKS = 4,
    parameter int CALM_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       target_valid,
    input  logic [2:0] target_amp,
    input  logic [2:0] target_freq,
    input  logic       stress_low,
    input  logic       error,
    input  logic       fault_clr,
    output logic [2:0] amp,
    output logic [2:0] freq,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state
);

`ifdef SOFT_START_EN
    localparam int SW = $clog2(STEP_TICKS) + 2;
    localparam logic [SW-1:0] LIM_UP = SW'(2 * STEP_TICKS - 1);
`else
    localparam int SW = $clog2(STEP_TICKS) + 1;
`endif
    localparam logic [SW-1:0] LIM_N = SW'(STEP_TICKS - 1);
    localparam int CW = $clog2(CALM_TICKS + 1);
    localparam logic [CW-1:0] CALM_MAX = CW'(CALM_TICKS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_AMP_DOWN = 3'd1,
        S_FREQ     = 3'd2,
        S_AMP_UP   = 3'd3,
        S_HOLD     = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    state_t        state_q, state_d, kind;
    logic [2:0]    amp_q, amp_d, freq_q, freq_d;
    logic [2:0]    t_amp_q, t_amp_d, t_freq_q, t_freq_d;
    logic [SW-1:0] step_q, step_d, lim;
    logic [CW-1:0] calm_q, calm_d;
    logic          fault_q, fault_d;
    logic          busy_int, calm_force, step_due, at_target, t_changed;

    // Saturating level moves: levels never wrap past 0 or 7.
    function automatic logic [2:0] lvl_up(input logic [2:0] x);
        return (x == 3'd7) ? 3'd7 : x + 3'd1;
    endfunction

    function automatic logic [2:0] lvl_dn(input logic [2:0] x);
        return (x == 3'd0) ? 3'd0 : x - 3'd1;
    endfunction

    assign busy_int = (amp_q != t_amp_q) || (freq_q != t_freq_q);
    assign busy     = busy_int && (state_q != S_FAULT);
    assign amp      = amp_q;
    assign freq     = freq_q;
    assign fault    = fault_q;
    assign state    = state_q;

    // State register; reset returns every register to rest in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            amp_q    <= '0;
            freq_q   <= '0;
            t_amp_q  <= '0;
            t_freq_q <= '0;
            step_q   <= '0;
            calm_q   <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            amp_q    <= amp_d;
            freq_q   <= freq_d;
            t_amp_q  <= t_amp_d;
            t_freq_q <= t_freq_d;
            step_q   <= step_d;
            calm_q   <= calm_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state: calm timer, target latch, step scheduling and fault handling.
    always_comb begin
        state_d   = state_q;
        amp_d     = amp_q;
        freq_d    = freq_q;
        t_amp_d   = t_amp_q;
        t_freq_d  = t_freq_q;
        step_d    = step_q;
        calm_d    = calm_q;
        fault_d   = fault_q;
        kind      = S_HOLD;
        lim       = LIM_N;
        at_target = 1'b0;
        t_changed = 1'b0;

        // Calm counter saturates at CALM_TICKS; every tick at saturation re-forces rest.
        if (!stress_low) begin
            calm_d = '0;
        end else if (tick && (calm_q != CALM_MAX)) begin
            calm_d = calm_q + 1'b1;
        end
        calm_force = stress_low && tick && (calm_q >= CALM_MAX - 1'b1);

        // Step priority: lower amp, then move freq, then raise amp.
        if (amp_q > t_amp_q) begin
            kind = S_AMP_DOWN;
        end else if (freq_q != t_freq_q) begin
            kind = S_FREQ;
        end else if (amp_q < t_amp_q) begin
            kind = S_AMP_UP;
        end
`ifdef SOFT_START_EN
        if (kind == S_AMP_UP) begin
            lim = LIM_UP;
        end
`endif
        step_due = tick && busy_int && (step_q >= lim);

        if (state_q == S_FAULT) begin
            step_d   = '0;
            t_amp_d  = '0;
            t_freq_d = '0;
            if (fault_clr && !error) begin
                // Leave fault at the current levels; sequencing toward 0/0 resumes.
                fault_d = 1'b0;
                state_d = (amp_q == 3'd0 && freq_q == 3'd0) ? S_IDLE : S_HOLD;
            end else if (tick) begin
                if (amp_q != 3'd0) begin
                    amp_d = lvl_dn(amp_q);
                end else begin
                    freq_d = lvl_dn(freq_q);
                end
            end
        end else if (error) begin
            state_d  = S_FAULT;
            fault_d  = 1'b1;
            t_amp_d  = '0;
            t_freq_d = '0;
            step_d   = '0;
        end else begin
            if (calm_force) begin
                t_amp_d  = '0;
                t_freq_d = '0;
            end else if (target_valid) begin
                t_amp_d  = target_amp;
                t_freq_d = target_freq;
            end
            t_changed = (t_amp_d != t_amp_q) || (t_freq_d != t_freq_q);

            if (step_due) begin
                step_d = '0;
                case (kind)
                    S_AMP_DOWN: amp_d  = lvl_dn(amp_q);
                    S_FREQ:     freq_d = (freq_q < t_freq_q) ? lvl_up(freq_q) : lvl_dn(freq_q);
                    S_AMP_UP:   amp_d  = lvl_up(amp_q);
                    default:    ;
                endcase
            end else if (tick && busy_int) begin
                step_d = step_q + 1'b1;
            end

            at_target = (amp_d == t_amp_d) && (freq_d == t_freq_d);
            if (at_target) begin
                state_d = (amp_d == 3'd0 && freq_d == 3'd0) ? S_IDLE : S_HOLD;
            end else if (step_due) begin
                state_d = kind;
            end

            // A fresh target seen from rest starts a full step interval.
            if (t_changed && !at_target && (state_q == S_IDLE || state_q == S_HOLD)) begin
                step_d = '0;
            end
        end
    end

endmodule

// File: tb/tb_rock_sequencer.sv
// Directed bench for rock_sequencer with STEP_TICKS=4, CALM_TICKS=16 and tick
// held high on every clock unless noted.
module tb_rock_sequencer;

    localparam int ST = 4;
`ifdef SOFT_START_EN
    localparam int UP = 2 * ST;
`else
    localparam int UP = ST;
`endif

    logic       clk = 1'b0;
    logic       reset, tick, target_valid, stress_low, error, fault_clr;
    logic [2:0] target_amp, target_freq;
    logic [2:0] amp, freq, state;
    logic       busy, fault;

    int n_chk  = 0;
    int n_fail = 0;

    rock_sequencer #(.STEP_TICKS(ST), .CALM_TICKS(16)) dut (
        .clk(clk), .reset(reset), .tick(tick), .target_valid(target_valid),
        .target_amp(target_amp), .target_freq(target_freq),
        .stress_low(stress_low), .error(error), .fault_clr(fault_clr),
        .amp(amp), .freq(freq), .busy(busy), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch(input logic [2:0] a, input logic [2:0] f);
        target_valid = 1'b1;
        target_amp   = a;
        target_freq  = f;
        cycle(1);
        target_valid = 1'b0;
    endtask

    task automatic chk_lv(input string tag, input int a, input int f, input int s);
        chk({tag, ".amp"}, amp, a);
        chk({tag, ".freq"}, freq, f);
        chk({tag, ".state"}, state, s);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; target_valid = 1'b0; stress_low = 1'b0;
        error = 1'b0; fault_clr = 1'b0; target_amp = '0; target_freq = '0;
        cycle(2);
        chk_lv("reset", 0, 0, 0);
        chk("reset.busy", busy, 0);
        chk("reset.fault", fault, 0);

        // Ramp 0/0 -> 3/5: frequency first, then amplitude
        reset = 1'b0; tick = 1'b1;
        latch(3'd3, 3'd5);
        chk("up.busy_latched", busy, 1);
        chk("up.state_latched", state, 0);
        cycle(3);
        chk("up.freq_before_first", freq, 0);
        cycle(1);
        chk_lv("up.first_step", 0, 1, 2);
        cycle(16);
        chk_lv("up.freq_done", 0, 5, 2);
        cycle(2 * UP);
        chk_lv("up.amp2", 2, 5, 3);
        chk("up.busy_mid", busy, 1);
        cycle(UP);
        chk_lv("up.hold", 3, 5, 4);
        chk("up.busy_done", busy, 0);

        // 3/5 -> 1/2: amplitude lowered before frequency moves
        latch(3'd1, 3'd2);
        cycle(4);
        chk_lv("dn.amp2", 2, 5, 1);
        cycle(4);
        chk_lv("dn.amp1", 1, 5, 1);
        cycle(4);
        chk_lv("dn.freq4", 1, 4, 2);
        cycle(8);
        chk_lv("dn.hold", 1, 2, 4);

        // Back to 3/5, then error shutdown
        latch(3'd3, 3'd5);
        cycle(12 + 2 * UP);
        chk_lv("re.hold", 3, 5, 4);
        error = 1'b1;
        cycle(1);
        error = 1'b0;
        chk_lv("flt.entry", 3, 5, 5);
        chk("flt.fault", fault, 1);
        chk("flt.busy", busy, 0);
        latch(3'd7, 3'd7);
        chk("flt.amp2", amp, 2);
        cycle(2);
        chk_lv("flt.amp0", 0, 5, 5);
        cycle(1);
        chk("flt.freq4", freq, 4);
        cycle(4);
        chk_lv("flt.zero", 0, 0, 5);
        error = 1'b1; fault_clr = 1'b1;
        cycle(1);
        chk("flt.clr_ignored", fault, 1);
        error = 1'b0;
        cycle(1);
        fault_clr = 1'b0;
        chk("flt.cleared", fault, 0);
        chk_lv("flt.idle", 0, 0, 0);
        cycle(2);
        chk("flt.target_dropped", busy, 0);

        // Calm timeout from 3/5
        latch(3'd3, 3'd5);
        cycle(20 + 3 * UP);
        chk_lv("calm.hold", 3, 5, 4);
        stress_low = 1'b1;
        cycle(15);
        stress_low = 1'b0;
        cycle(1);
        chk("calm.early_busy", busy, 0);
        stress_low = 1'b1;
        cycle(15);
        chk("calm.15_busy", busy, 0);
        cycle(1);
        chk("calm.forced_busy", busy, 1);
        chk_lv("calm.forced", 3, 5, 4);
        cycle(4);
        chk_lv("calm.amp2", 2, 5, 1);
        cycle(8);
        chk_lv("calm.amp0", 0, 5, 1);
        cycle(20);
        chk_lv("calm.idle", 0, 0, 0);
        stress_low = 1'b0;
        cycle(1);

        // Retarget mid frequency ramp
        latch(3'd0, 3'd5);
        cycle(8);
        chk_lv("mid.freq2", 0, 2, 2);
        latch(3'd0, 3'd1);
        cycle(2);
        chk_lv("mid.wait", 0, 2, 2);
        cycle(1);
        chk_lv("mid.hold", 0, 1, 4);

        // Reset mid ramp, then frozen with tick low
        latch(3'd3, 3'd4);
        cycle(12 + 2 * UP);
        chk_lv("rst.mid", 2, 4, 3);
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        chk_lv("rst.zero", 0, 0, 0);
        chk("rst.busy", busy, 0);
        tick = 1'b0;
        latch(3'd5, 3'd5);
        cycle(10);
        chk_lv("frz", 0, 0, 0);
        chk("frz.busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rock_sequencer.md
Name: rock_sequencer

Overview:
- Rate-limited sequencer between the stress/controller stage and the output (PSfreq/PSamp) generator.
- Takes requested 3-bit amplitude/frequency targets and moves the live amp/freq one level at a time on the slow tick.
- Amplitude is never raised while frequency is changing, and is lowered before frequency moves.
- Handles calm-timeout return to rest and error-driven fast shutdown with a latched fault.

Parameters:
STEP_TICKS, 4, slow ticks between level steps (>=1)
CALM_TICKS, 16, consecutive ticks of stress_low before forcing rest target 0/0 (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  slow-time enable pulse, one clk wide
target_valid  in  1  latch target_amp/target_freq this cycle
target_amp  in  3  requested amplitude level
target_freq  in  3  requested frequency level
stress_low  in  1  baby calm indication (level)
error  in  1  controller/sensor error (level)
fault_clr  in  1  one-cycle fault acknowledge
amp  out  3  live amplitude level to output stage
freq  out  3  live frequency level to output stage
busy  out  1  live levels differ from latched target
fault  out  1  fault latched
state  out  3  0 IDLE, 1 AMP_DOWN, 2 FREQ, 3 AMP_UP, 4 HOLD, 5 FAULT

Behaviour:
- Reset (on clk edge with reset=1): amp=0, freq=0, latched target t_amp=t_freq=0, step and calm counters 0, state IDLE, busy 0, fault 0.
- Only clk edges with tick=1 advance counters or levels. Exceptions, which act on every clk: target latch, error entry, fault_clr.
- Target latch:
  - target_valid=1 and state!=FAULT -> t_amp/t_freq load next cycle; a newer value overwrites an older one.
  - Loading a target that differs from current amp/freq while in IDLE/HOLD clears the step counter.
- Step counter:
  - Increments on each tick while busy.
  - On the tick where it equals STEP_TICKS-1, one step is performed and the counter clears.
  - First step therefore lands on the STEP_TICKS-th tick after the latch.
- Step selection, priority re-evaluated at every step using current t_amp/t_freq:
  1. amp>t_amp -> amp-1, state AMP_DOWN
  2. else freq!=t_freq -> freq moves +/-1 toward t_freq, state FREQ
  3. else amp<t_amp -> amp+1, state AMP_UP
  4. else no step: state HOLD, or IDLE if amp=freq=0 and target 0/0
- busy is combinational: (amp!=t_amp)|(freq!=t_freq), forced 0 in FAULT. State updates to HOLD/IDLE in the cycle levels reach target.
- Calm timeout:
  - Calm counter increments on ticks with stress_low=1 and clears on any cycle with stress_low=0.
  - On reaching CALM_TICKS: t_amp=t_freq=0 and the counter saturates.
  - If target_valid arrives in the same cycle as the calm force, the calm force wins.
  - While saturated and stress_low=1, target_valid still loads, but the target is re-forced to 0/0 on the next tick.
- Fault:
  - error=1 on any clk (not in reset) -> state FAULT next cycle, fault=1, t_amp=t_freq=0.
  - Error overrides target_valid and calm in the same cycle.
  - In FAULT, STEP_TICKS is ignored and one level drops per tick: amp first down to 0, then freq down to 0.
  - Exit only on fault_clr=1 while error=0, regardless of levels: fault->0, state IDLE if amp=freq=0, else normal sequencing resumes toward 0/0.
  - fault_clr while error=1 is ignored.
- Widths: levels saturate at 0 and 7; no wrap. Step counter is sized clog2(STEP_TICKS)+1 bits; calm counter is sized to CALM_TICKS.
- Reset mid-ramp or in FAULT returns to the reset values in one cycle.

Optional Feature:
SOFT_START_EN
- Defined: AMP_UP steps require 2*STEP_TICKS ticks; AMP_DOWN and FREQ keep STEP_TICKS; FAULT is unaffected.
- Undefined: all normal steps use STEP_TICKS.

Test Plan:
- Reset, tick every clk, STEP_TICKS=4, target 3/5 -> freq 0->5 on ticks 4,8,...,20, then amp 0->3 on ticks 24,28,32; state FREQ then AMP_UP then HOLD; busy drops on the cycle amp=3.
- From HOLD 3/5, target 1/2 -> amp 3->2->1 first, then freq 5->4->3->2; amp never rises; final HOLD.
- At 3/5, pulse error 1 clk -> fault=1, t=0/0, amp 2,1,0 on next three ticks, then freq 4..0 one per tick; target_valid 7/7 ignored; fault_clr with error=0 -> fault=0, IDLE.
- At 3/5, stress_low high 16 ticks -> rest target forced; ramps to 0/0 (amp first), state IDLE; stress_low drop at tick 15 -> no change.
- Mid FREQ ramp (freq=2 toward 5, amp=0), target 0/1 -> next step freq 2->1, then HOLD; with SOFT_START_EN and target 2/1 -> amp steps every 8 ticks.
- Reset asserted mid-ramp at 2/4 -> next cycle amp=0, freq=0, IDLE; tick held 0 -> outputs frozen despite a pending target.
